seg_state_recover: RTL and testbench
====================================

Name: seg_state_recover

Overview:
- Inverse of the 2-bit state to 7-segment decoder: monitors an 8-bit segment bus and recovers the 2-bit state that drove it.
- Adds input synchronisation, glitch/settle filtering, change detection and illegal-pattern reporting.
- Sits on the observation/loop-back side of the display path.
- Used to confirm that the state shown on the display matches the FSM state, and to read state from an external display bus.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronised samples needed before a pattern is accepted (range 1..15).
- ERR_W, 8, width of the saturating illegal-pattern counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  8  segment bus, bit0=a … bit6=g, bit7=dot. Asynchronous to clk.
- clear_err  input  1  synchronous; clears err_sticky and err_count.
- state_out  output  2  last accepted legal state.
- state_valid  output  1  one-cycle pulse when a new legal pattern is accepted.
- locked  output  1  high once any legal pattern has been accepted since reset.
- illegal  output  1  one-cycle pulse when a new illegal pattern is accepted.
- err_sticky  output  1  set by illegal; cleared only by clear_err or reset.
- err_count  output  ERR_W  number of illegal acceptances; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser flops, sample history, settle counter and last_accepted (value 8'h00 plus a "none" flag) are cleared.
  - All outputs are 0: state_out=2'b00, state_valid=0, locked=0, illegal=0, err_sticky=0, err_count=0.
  - FSM enters UNLOCKED.
- Synchroniser: two flops on seg_in produce s2. s2 lags seg_in by 2 edges.
- Settle counter:
  - If s2 differs from its previous-cycle value, cnt is set to 1; otherwise cnt increments.
  - cnt saturates at STABLE_CYCLES.
  - "Settled" means cnt == STABLE_CYCLES.
- Acceptance: on the first settled cycle where s2 != last_accepted (or last_accepted is "none"), s2 is accepted and last_accepted <= s2.
- Legal table, exact 8-bit match (dot must be 0):
  - 8'h0E -> 2'b00
  - 8'h00 -> 2'b01
  - 8'h4A -> 2'b10
  - 8'h4F -> 2'b11
- Legal acceptance: state_out updated, state_valid=1 for one cycle, locked=1.
- Illegal acceptance (any other code, including dot=1):
  - state_out holds, illegal=1 for one cycle, err_sticky=1.
  - err_count increments unless already saturated.
- Latency: seg_in held constant from edge N means state_valid/illegal are high during the cycle following edge N+1+STABLE_CYCLES, i.e. STABLE_CYCLES+2 edges after first sampling. With default: 6 edges.
- FSM:
  - UNLOCKED -> SETTLE on any s2 change.
  - SETTLE -> LOCKED on legal acceptance.
  - SETTLE -> UNLOCKED on illegal acceptance, only if never locked.
  - SETTLE -> LOCKED on illegal acceptance if previously locked.
  - LOCKED -> SETTLE on s2 change.
  - In SETTLE, state_out and locked hold their old values.
- Boundary cases:
  - Glitch shorter than STABLE_CYCLES: no acceptance, no pulses. Counter restarts from 1 on every change.
  - Return to the same pattern as last_accepted after a glitch: no pulse.
  - Return to a legal pattern after an illegal acceptance: that legal pattern is accepted again and pulses.
  - clear_err in the same cycle as illegal: clear wins for err_sticky and err_count. The illegal pulse still asserts.
  - err_count at max: stays at max, err_sticky still set.
  - STABLE_CYCLES=1: accepted on the first cycle s2 shows a new value.
  - rst_n asserted mid-settle: immediate clear. After release, the pattern must settle again from cnt=0.

Test Plan:
- Reset, then seg_in=8'h4F held from edge 0 -> state_valid pulses once in the cycle after edge 5; state_out=2'b11; locked=1; no further pulses while held.
- Sequence 8'h0E, 8'h00, 8'h4A, each held 10 cycles -> three state_valid pulses, state_out 00, 01, 10 in order, illegal never asserted.
- From locked 8'h4A, apply 8'h4F for 3 cycles, then back to 8'h4A -> no state_valid, no illegal; state_out stays 2'b10.
- Apply 8'h8E (dot set) for 8 cycles -> illegal pulse, err_sticky=1, err_count=1, state_out holds. Then 8'h4A -> state_valid pulse again.
- Twelve illegal acceptances with ERR_W=3 -> err_count saturates at 7. clear_err coincident with the 13th illegal -> err_count=0, err_sticky=0, illegal pulse seen.
- rst_n low for 1 cycle while 8'h00 is settling (cnt=2) -> all outputs 0 immediately. After release with input held, state_valid arrives 6 edges later.

Source files
------------

// File: rtl/seg_state_recover.sv
// Recovers the 2-bit FSM state from an asynchronous 7-segment (+dot) bus:
// synchronises, waits for the pattern to settle, then reports legal/illegal acceptances.
module seg_state_recover #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       seg_in,
    input  logic             clear_err,
    output logic [1:0]       state_out,
    output logic             state_valid,
    output logic             locked,
    output logic             illegal,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [3:0]       STABLE_L = 4'(STABLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_LOCKED   = 2'd2
    } fsm_e;

    // Returns {legal, state}; the dot segment must be off for a legal code.
    function automatic logic [2:0] decode_seg(input logic [7:0] code);
        logic [2:0] res;
        case (code)
            8'h0E:   res = 3'b100;
            8'h00:   res = 3'b101;
            8'h4A:   res = 3'b110;
            8'h4F:   res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    logic [7:0]       sync1_q, s2_q, prev_q, last_q;
    logic             sync1_vld_q, s2_vld_q, prev_vld_q, last_none_q;
    logic [3:0]       cnt_q, cnt_d;
    fsm_e             fsm_q;
    logic [1:0]       state_out_q;
    logic             state_valid_q, locked_q, illegal_q, err_sticky_q;
    logic [ERR_W-1:0] err_count_q;

    logic             changed_s, accept_s, legal_acc_s, illegal_acc_s;
    logic [2:0]       dec_s;

    // Settle counter and acceptance decision; the valid bits keep the
    // pipeline-fill cycles after reset from counting as settled samples.
    always_comb begin
        changed_s = s2_vld_q && (!prev_vld_q || (s2_q != prev_q));
        cnt_d     = cnt_q;
        if (!s2_vld_q) begin
            cnt_d = 4'd0;
        end else if (changed_s) begin
            cnt_d = 4'd1;
        end else if (cnt_q < STABLE_L) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
        accept_s      = (cnt_d == STABLE_L) && (last_none_q || (s2_q != last_q));
        dec_s         = decode_seg(s2_q);
        legal_acc_s   = accept_s && dec_s[2];
        illegal_acc_s = accept_s && !dec_s[2];
    end

    // Synchroniser, sample history, settle counter and last accepted pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 8'h00;
            s2_q        <= 8'h00;
            prev_q      <= 8'h00;
            last_q      <= 8'h00;
            sync1_vld_q <= 1'b0;
            s2_vld_q    <= 1'b0;
            prev_vld_q  <= 1'b0;
            last_none_q <= 1'b1;
            cnt_q       <= 4'd0;
        end else begin
            sync1_q     <= seg_in;
            s2_q        <= sync1_q;
            prev_q      <= s2_q;
            sync1_vld_q <= 1'b1;
            s2_vld_q    <= sync1_vld_q;
            prev_vld_q  <= s2_vld_q;
            cnt_q       <= cnt_d;
            if (accept_s) begin
                last_q      <= s2_q;
                last_none_q <= 1'b0;
            end else begin
                last_q      <= last_q;
                last_none_q <= last_none_q;
            end
        end
    end

    // Lock FSM with registered outputs and the error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q         <= ST_UNLOCKED;
            state_out_q   <= 2'b00;
            state_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            illegal_q     <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_count_q   <= {ERR_W{1'b0}};
        end else begin
            // With STABLE_CYCLES=1 a change and an acceptance coincide, so
            // acceptance is honoured from any state.
            case (fsm_q)
                ST_SETTLE: begin
                    if (legal_acc_s) begin
                        fsm_q <= ST_LOCKED;
                    end else if (illegal_acc_s) begin
                        fsm_q <= locked_q ? ST_LOCKED : ST_UNLOCKED;
                    end else begin
                        fsm_q <= ST_SETTLE;
                    end
                end
                ST_UNLOCKED, ST_LOCKED: begin
                    if (legal_acc_s) begin
                        fsm_q <= ST_LOCKED;
                    end else if (illegal_acc_s) begin
                        fsm_q <= locked_q ? ST_LOCKED : ST_UNLOCKED;
                    end else if (changed_s) begin
                        fsm_q <= ST_SETTLE;
                    end else begin
                        fsm_q <= fsm_q;
                    end
                end
                default: fsm_q <= ST_UNLOCKED;
            endcase

            state_valid_q <= legal_acc_s;
            illegal_q     <= illegal_acc_s;
            if (legal_acc_s) begin
                state_out_q <= dec_s[1:0];
                locked_q    <= 1'b1;
            end else begin
                state_out_q <= state_out_q;
                locked_q    <= locked_q;
            end

            if (clear_err) begin
                err_sticky_q <= 1'b0;
                err_count_q  <= {ERR_W{1'b0}};
            end else if (illegal_acc_s) begin
                err_sticky_q <= 1'b1;
                err_count_q  <= (err_count_q == ERR_MAX) ? ERR_MAX : err_count_q + ERR_ONE;
            end else begin
                err_sticky_q <= err_sticky_q;
                err_count_q  <= err_count_q;
            end
        end
    end

    assign state_out   = state_out_q;
    assign state_valid = state_valid_q;
    assign locked      = locked_q;
    assign illegal     = illegal_q;
    assign err_sticky  = err_sticky_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_seg_state_recover.sv
// Randomised bench for seg_state_recover: two instances (STABLE_CYCLES 4 and 1)
// compared every cycle against a sliding-window reference model.
module tb_seg_state_recover;

    logic       clk;
    logic       rst_n;
    logic       clear_err;
    logic [7:0] seg_in;

    logic [1:0] st_a, st_b;
    logic       sv_a, sv_b, lk_a, lk_b, il_a, il_b, es_a, es_b;
    logic [2:0] ec_a;
    logic [7:0] ec_b;

    seg_state_recover #(.STABLE_CYCLES(4), .ERR_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clear_err(clear_err),
        .state_out(st_a), .state_valid(sv_a), .locked(lk_a), .illegal(il_a),
        .err_sticky(es_a), .err_count(ec_a)
    );

    seg_state_recover #(.STABLE_CYCLES(1), .ERR_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .clear_err(clear_err),
        .state_out(st_b), .state_valid(sv_b), .locked(lk_b), .illegal(il_b),
        .err_sticky(es_b), .err_count(ec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pattern is accepted when the last STABLE samples that
    // have passed the two-flop synchroniser are all present and identical.
    int         sk[2]   = '{4, 1};
    int         cmax[2] = '{7, 255};
    logic [7:0] legal_codes[4] = '{8'h0E, 8'h00, 8'h4A, 8'h4F};
    logic [7:0] hv_val[2][0:16];
    bit         hv_ok[2][0:16];
    logic [7:0] m_last[2];
    bit         m_none[2], m_locked[2], m_valid[2], m_ill[2], m_sticky[2];
    logic [1:0] m_state[2];
    int         m_count[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j <= 16; j++) begin
                hv_ok[k][j]  = 1'b0;
                hv_val[k][j] = 8'h00;
            end
            m_none[k]   = 1'b1;
            m_last[k]   = 8'h00;
            m_state[k]  = 2'b00;
            m_locked[k] = 1'b0;
            m_valid[k]  = 1'b0;
            m_ill[k]    = 1'b0;
            m_sticky[k] = 1'b0;
            m_count[k]  = 0;
        end
    endtask

    task automatic model_edge(input logic [7:0] seg, input bit clr);
        bit settled;
        int idx;
        for (int k = 0; k < 2; k++) begin
            settled = 1'b1;
            for (int j = 1; j <= sk[k]; j++)
                if (!hv_ok[k][j] || hv_val[k][j] != hv_val[k][1]) settled = 1'b0;
            m_valid[k] = 1'b0;
            m_ill[k]   = 1'b0;
            if (settled && (m_none[k] || hv_val[k][1] != m_last[k])) begin
                idx = -1;
                for (int i = 0; i < 4; i++)
                    if (legal_codes[i] == hv_val[k][1]) idx = i;
                m_none[k] = 1'b0;
                m_last[k] = hv_val[k][1];
                if (idx >= 0) begin
                    m_valid[k]  = 1'b1;
                    m_state[k]  = 2'(idx);
                    m_locked[k] = 1'b1;
                end else begin
                    m_ill[k]    = 1'b1;
                    m_sticky[k] = 1'b1;
                    if (m_count[k] < cmax[k]) m_count[k]++;
                end
            end
            if (clr) begin
                m_sticky[k] = 1'b0;
                m_count[k]  = 0;
            end
            for (int j = 16; j >= 1; j--) begin
                hv_val[k][j] = hv_val[k][j-1];
                hv_ok[k][j]  = hv_ok[k][j-1];
            end
            hv_val[k][0] = seg;
            hv_ok[k][0]  = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_val("A.state_out",   32'(st_a), 32'(m_state[0]));
        check_val("A.state_valid", 32'(sv_a), 32'(m_valid[0]));
        check_val("A.locked",      32'(lk_a), 32'(m_locked[0]));
        check_val("A.illegal",     32'(il_a), 32'(m_ill[0]));
        check_val("A.err_sticky",  32'(es_a), 32'(m_sticky[0]));
        check_val("A.err_count",   32'(ec_a), 32'(m_count[0]));
        check_val("B.state_out",   32'(st_b), 32'(m_state[1]));
        check_val("B.state_valid", 32'(sv_b), 32'(m_valid[1]));
        check_val("B.locked",      32'(lk_b), 32'(m_locked[1]));
        check_val("B.illegal",     32'(il_b), 32'(m_ill[1]));
        check_val("B.err_sticky",  32'(es_b), 32'(m_sticky[1]));
        check_val("B.err_count",   32'(ec_b), 32'(m_count[1]));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs checked 1 unit after.
    task automatic tick(input logic [7:0] seg, input bit clr);
        seg_in    = seg;
        clear_err = clr;
        @(posedge clk);
        if (rst_n) model_edge(seg, clr);
        #1;
        check_outputs();
    endtask

    task automatic hold(input logic [7:0] seg, input int n);
        for (int i = 0; i < n; i++) tick(seg, 1'b0);
    endtask

    task automatic pulse_reset();
        clear_err = 1'b0;
        rst_n     = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] code;
    int         len;

    initial begin
        rst_n     = 1'b1;
        seg_in    = 8'h00;
        clear_err = 1'b0;
        #1;
        pulse_reset();

        // 4F from edge 0: single pulse after edge 5, then quiet while held.
        for (int i = 0; i < 12; i++) begin
            tick(8'h4F, 1'b0);
            check_val("lat.first_valid", 32'(sv_a), 32'(i == 5));
        end
        check_val("lat.first_state", 32'(st_a), 32'd3);

        hold(8'h0E, 10);
        hold(8'h00, 10);
        hold(8'h4A, 10);

        // Short glitch back to the locked pattern: nothing reported.
        hold(8'h4F, 3);
        hold(8'h4A, 10);
        check_val("glitch.state", 32'(st_a), 32'd2);

        hold(8'h8E, 8);
        check_val("dot.state_hold", 32'(st_a), 32'd2);
        hold(8'h4A, 10);

        for (int i = 0; i < 12; i++) hold((i % 2) ? 8'h11 : 8'h8E, 6);
        check_val("sat.count", 32'(ec_a), 32'd7);
        check_val("sat.sticky", 32'(es_a), 32'd1);
        hold(8'h22, 5);
        tick(8'h22, 1'b1);
        check_val("clr.illegal", 32'(il_a), 32'd1);
        check_val("clr.count", 32'(ec_a), 32'd0);
        check_val("clr.sticky", 32'(es_a), 32'd0);

        // Reset while 00 is mid-settle, then settle again from scratch.
        hold(8'h00, 3);
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            tick(8'h00, 1'b0);
            check_val("lat.after_reset", 32'(sv_a), 32'(i == 5));
        end

        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 5))
                0: code = legal_codes[0];
                1: code = legal_codes[1];
                2: code = legal_codes[2];
                3: code = legal_codes[3];
                4: code = legal_codes[$urandom_range(0, 3)] | 8'h80;
                default: code = 8'($urandom_range(0, 255));
            endcase
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) tick(code, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 40) == 0) pulse_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
